led_share_arbiter: RTL and testbench
====================================

# led_share_arbiter

Round-robin arbiter that shares the 8-LED output bank among NREQ pattern requesters. Each granted requester's pattern is latched and shown for a programmable dwell time, then the bank is blanked for a fixed gap before the next grant. Sits between pattern-generating blocks and the board LED pins, and is the sole driver of `led`.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `DWELL_W`, 24: width of the dwell counter and `dwell` input.
- `GAP`, 2: blank cycles between shows, ≥1.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `nreset`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  per-requester request level; hold high until `done` or to abort.
- `pattern`  in  NREQ*8  requester i pattern in bits [8i+7:8i].
- `dwell`  in  DWELL_W  show duration in cycles; 0 treated as 1.
- `grant`  out  NREQ  one-hot current owner; 0 when idle or in gap.
- `done`  out  NREQ  one-cycle completion pulse to the owner.
- `led`  out  8  registered LED drive.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, SHOW, BLANK.
- All outputs and state are registered. Asynchronous reset sets: state=IDLE, `grant`=0, `done`=0, `led`=0, `busy`=0, counter=0, last-owner pointer=NREQ-1 (requester 0 has first priority).
- IDLE:
  - If any `req` bit is high, select the first set bit searching from last+1 upward, wrapping modulo NREQ.
  - Next cycle: `grant` is one-hot on the winner, `led` = winner's `pattern` slice, counter = max(`dwell`,1)-1, last = winner, state=SHOW.
- SHOW:
  - `led` and `grant` are held. `pattern` and `dwell` are not re-sampled.
  - While counter≠0 and `req[owner]`=1, the counter decrements by 1.
  - Counter==0 (completion): next cycle `done[owner]`=1 for one cycle, `grant`=0, `led`=0, counter=GAP-1, state=BLANK.
  - `req[owner]`=0 with counter≠0 (abort): next cycle `grant`=0, `led`=0, no `done`, counter=GAP-1, state=BLANK. The pointer still advances past the aborted owner.
  - Completion and `req[owner]` falling in the same cycle: completion wins and `done` pulses.
  - Changes to other requesters' `req` during SHOW have no effect.
- BLANK:
  - `led`=0 and `grant`=0. Counter decrements each cycle.
  - Counter==0: next state IDLE.
- `done` is never high in more than one bit, or for more than one cycle.
- Reset mid-SHOW or mid-BLANK immediately clears all outputs. No `done` is produced.

## Timing
- Request seen in IDLE at cycle N: `grant` and `led` are valid from N+1.
- Show length is D=max(`dwell`,1). `led` holds the pattern for cycles N+1..N+D.
- `done` is high at N+D+1. `led` is 0 and `grant` is 0 from N+D+1.
- BLANK occupies N+D+1..N+D+GAP. State is IDLE at N+D+GAP+1. The earliest next grant is at N+D+GAP+2.
- Abort: `req[owner]` low sampled at cycle M in SHOW gives `led`=0 and `grant`=0 at M+1, and IDLE at M+GAP+1.
- `busy` = (state≠IDLE), registered alongside state.

## Test plan
- Reset, then `req`=4'b0001, pattern0=8'hA5, `dwell`=5, GAP=2 -> `grant`=0001 and `led`=A5 for exactly 5 cycles; `done[0]` pulses the next cycle with `led`=00; `busy` falls 3 cycles after the last A5 cycle.
- `req`=4'b1111 held with distinct patterns 11/22/44/88 -> grant order 0,1,2,3,0, with each `done` one cycle wide and exactly 3 blank cycles between shows (GAP=2 plus IDLE).
- `dwell`=0 -> pattern shown for exactly 1 cycle, then `done`; `dwell`=1 gives identical behaviour.
- Owner drops `req` on show cycle 2 of 5 -> `led`=00 the next cycle and no `done`; the next grant goes to the following requester in round-robin order, not the aborted one.
- Change `pattern` and `dwell` mid-SHOW -> `led` and show length remain at the values latched at grant.
- Assert `nreset` low mid-SHOW -> `led`, `grant`, `done` and `busy` are 0 immediately, without waiting for a clock edge; after release with `req`=4'b1010, requester 1 is granted first.

Source files
------------

// File: rtl/led_share_arbiter_if.sv
// Bundle of signals between the pattern requesters and the LED share arbiter.
//   master : requester side, which drives req/pattern/dwell and observes grant/done/led/busy
//   slave  : arbiter side, which samples req/pattern/dwell and drives grant/done/led/busy
interface led_share_arbiter_if #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DWELL_W = 24
);
    logic [NREQ-1:0]   req;
    logic [NREQ*8-1:0] pattern;
    logic [DWELL_W-1:0] dwell;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic [7:0]        led;
    logic              busy;

    modport master (
        output req, pattern, dwell,
        input  grant, done, led, busy
    );

    modport slave (
        input  req, pattern, dwell,
        output grant, done, led, busy
    );
endinterface

// File: rtl/led_share_arbiter.sv
// Round-robin arbiter sharing the 8-LED bank among NREQ pattern requesters.
// A granted requester's pattern is latched and shown for max(dwell,1) cycles,
// after which the bank is blanked for GAP cycles before the next grant.
// Ports:
//   clk     : rising-edge clock
//   nreset  : asynchronous active-low reset
//   bus     : slave side of led_share_arbiter_if
//             (req/pattern/dwell in; grant/done/led/busy out, all registered)
module led_share_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DWELL_W = 24,
    parameter int unsigned GAP     = 2
) (
    input  logic                  clk,
    input  logic                  nreset,
    led_share_arbiter_if.slave    bus
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [DWELL_W-1:0] GAP_M1 = DWELL_W'(GAP - 1);
    localparam logic [IDX_W-1:0]   LAST_RST = IDX_W'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHOW  = 2'd1,
        S_BLANK = 2'd2
    } state_e;

    state_e             state_q;
    logic [DWELL_W-1:0] cnt_q;
    logic [IDX_W-1:0]   last_q;
    logic [NREQ-1:0]    grant_q;
    logic [NREQ-1:0]    done_q;
    logic [7:0]         led_q;
    logic               busy_q;

    logic [IDX_W-1:0]   win_idx_c;
    logic               win_vld_c;
    logic [DWELL_W-1:0] show_cnt_c;

    // First requester at or after last+1, wrapping; descending scan so the
    // closest candidate is the final assignment.
    always_comb begin
        int cand;
        cand      = 0;
        win_idx_c = '0;
        win_vld_c = 1'b0;
        for (int k = int'(NREQ); k >= 1; k--) begin
            cand = (int'(last_q) + k) % int'(NREQ);
            if (bus.req[IDX_W'(cand)]) begin
                win_vld_c = 1'b1;
                win_idx_c = IDX_W'(cand);
            end
        end
    end

    // Dwell of 0 behaves as 1, so the loaded count is max(dwell,1)-1.
    assign show_cnt_c = (bus.dwell == '0) ? '0 : (bus.dwell - DWELL_W'(1));

    // State machine with registered outputs.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            last_q  <= LAST_RST;
            grant_q <= '0;
            done_q  <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (win_vld_c) begin
                        state_q <= S_SHOW;
                        busy_q  <= 1'b1;
                        grant_q <= NREQ'(1) << win_idx_c;
                        led_q   <= bus.pattern[{win_idx_c, 3'b000} +: 8];
                        cnt_q   <= show_cnt_c;
                        last_q  <= win_idx_c;
                    end
                end
                S_SHOW: begin
                    // Completion takes priority over a simultaneous req drop.
                    if (cnt_q == '0) begin
                        state_q <= S_BLANK;
                        done_q  <= NREQ'(1) << last_q;
                        grant_q <= '0;
                        led_q   <= '0;
                        cnt_q   <= GAP_M1;
                    end else if (!bus.req[last_q]) begin
                        state_q <= S_BLANK;
                        grant_q <= '0;
                        led_q   <= '0;
                        cnt_q   <= GAP_M1;
                    end else begin
                        cnt_q <= cnt_q - DWELL_W'(1);
                    end
                end
                S_BLANK: begin
                    if (cnt_q == '0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - DWELL_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    grant_q <= '0;
                    led_q   <= '0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.led   = led_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_led_share_arbiter.sv
// Self-checking bench for led_share_arbiter. A cycle-indexed reference model
// keeps each show as a time window [show_s, show_e] plus done/free times.
module tb_led_share_arbiter;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned DWELL_W = 24;
    localparam int unsigned GAP     = 2;

    logic clk;
    logic nreset;

    led_share_arbiter_if #(.NREQ(NREQ), .DWELL_W(DWELL_W)) bus ();

    led_share_arbiter #(.NREQ(NREQ), .DWELL_W(DWELL_W), .GAP(GAP)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;
    int t;

    // Reference model: time windows in absolute cycle numbers.
    int m_last, m_owner, m_show_s, m_show_e, m_done_t, m_free_t;
    logic [7:0] m_pat;
    logic [NREQ-1:0] exp_grant, exp_done;
    logic [7:0] exp_led;
    logic exp_busy;

    task automatic model_reset();
        m_last   = NREQ - 1;
        m_owner  = 0;
        m_pat    = 8'h00;
        m_show_s = 1;
        m_show_e = 0;
        m_done_t = -1;
        m_free_t = 0;
        exp_grant = '0;
        exp_done  = '0;
        exp_led   = 8'h00;
        exp_busy  = 1'b0;
    endtask

    // One clock: model consumes the inputs sampled at this edge, then we land
    // on the falling edge where outputs are compared.
    task automatic step();
        int w, d;
        bit found;
        @(posedge clk);
        if (nreset) begin
            if (t >= m_free_t && bus.req != '0) begin
                found = 0;
                w = 0;
                for (int k = 1; k <= int'(NREQ); k++) begin
                    if (!found && bus.req[(m_last + k) % NREQ]) begin
                        found = 1;
                        w = (m_last + k) % NREQ;
                    end
                end
                d = (bus.dwell == 0) ? 1 : int'(bus.dwell);
                m_owner  = w;
                m_last   = w;
                m_pat    = bus.pattern[8*w +: 8];
                m_show_s = t + 1;
                m_show_e = t + d;
                m_done_t = t + d + 1;
                m_free_t = t + d + GAP + 1;
            end else if (t >= m_show_s && t < m_show_e && !bus.req[m_owner]) begin
                m_show_e = t;
                m_done_t = -1;
                m_free_t = t + GAP + 1;
            end
        end
        t++;
        if (t >= m_show_s && t <= m_show_e) begin
            exp_grant = NREQ'(1) << m_owner;
            exp_led   = m_pat;
        end else begin
            exp_grant = '0;
            exp_led   = 8'h00;
        end
        exp_done = (t == m_done_t) ? (NREQ'(1) << m_owner) : '0;
        exp_busy = (t >= m_show_s && t < m_free_t);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        nreset  = 1'b0;
        bus.req = '0;
        #1;
        model_reset();
        repeat (2) @(negedge clk);
        nreset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        nreset = 1'b0;
        #1;
        n_tests++;
        if (bus.grant !== '0) begin n_fail++; $display("FAIL reset_grant got=%b want=0", bus.grant); end
        n_tests++;
        if (bus.done !== '0) begin n_fail++; $display("FAIL reset_done got=%b want=0", bus.done); end
        n_tests++;
        if (bus.led !== 8'h00) begin n_fail++; $display("FAIL reset_led got=%h want=00", bus.led); end
        n_tests++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        model_reset();
        @(negedge clk);
        nreset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if ({bus.grant, bus.done, bus.led, bus.busy} !== {exp_grant, exp_done, exp_led, exp_busy}) begin
                n_fail++;
                $display("FAIL reset_idle t=%0d got g=%b d=%b led=%h b=%b want g=%b d=%b led=%h b=%b",
                         t, bus.grant, bus.done, bus.led, bus.busy, exp_grant, exp_done, exp_led, exp_busy);
            end
        end
    endtask

    task automatic test_single();
        int a5_cnt, last_a5, done_at, busy_fall;
        logic [7:0] led_at_done;
        apply_reset();
        bus.pattern = 32'h0000_00A5;
        bus.dwell   = 24'd5;
        bus.req     = 4'b0001;
        a5_cnt = 0; last_a5 = -1; done_at = -1; busy_fall = -1; led_at_done = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            step();
            n_tests++;
            if ({bus.grant, bus.done, bus.led, bus.busy} !== {exp_grant, exp_done, exp_led, exp_busy}) begin
                n_fail++;
                $display("FAIL single t=%0d got g=%b d=%b led=%h b=%b want g=%b d=%b led=%h b=%b",
                         t, bus.grant, bus.done, bus.led, bus.busy, exp_grant, exp_done, exp_led, exp_busy);
            end
            if (bus.led == 8'hA5 && bus.grant == 4'b0001) begin a5_cnt++; last_a5 = t; end
            if (bus.done[0] && done_at < 0) begin done_at = t; led_at_done = bus.led; end
            if (!bus.busy && last_a5 >= 0 && busy_fall < 0) busy_fall = t;
        end
        bus.req = '0;
        n_tests++;
        if (a5_cnt !== 5) begin n_fail++; $display("FAIL single_len got=%0d want=5", a5_cnt); end
        n_tests++;
        if (done_at !== last_a5 + 1 || led_at_done !== 8'h00) begin
            n_fail++;
            $display("FAIL single_done got at=%0d led=%h want at=%0d led=00", done_at, led_at_done, last_a5 + 1);
        end
        n_tests++;
        if (busy_fall - last_a5 !== 3) begin n_fail++; $display("FAIL single_busy_fall got=%0d want=3", busy_fall - last_a5); end
        repeat (4) step();
    endtask

    task automatic test_round_robin();
        int order[$];
        int gaps[$];
        int zeros, o;
        logic [NREQ-1:0] prev;
        int want_order[5] = '{0, 1, 2, 3, 0};
        apply_reset();
        bus.pattern = 32'h8844_2211;
        bus.dwell   = 24'd2;
        bus.req     = 4'b1111;
        prev = '0; zeros = 0;
        for (int i = 0; i < 80 && order.size() < 5; i++) begin
            step();
            n_tests++;
            if ({bus.grant, bus.done, bus.led, bus.busy} !== {exp_grant, exp_done, exp_led, exp_busy}) begin
                n_fail++;
                $display("FAIL rr t=%0d got g=%b d=%b led=%h b=%b want g=%b d=%b led=%h b=%b",
                         t, bus.grant, bus.done, bus.led, bus.busy, exp_grant, exp_done, exp_led, exp_busy);
            end
            if (bus.grant != '0 && prev == '0) begin
                o = -1;
                for (int k = 0; k < int'(NREQ); k++) if (bus.grant[k]) o = k;
                if (order.size() > 0) gaps.push_back(zeros);
                order.push_back(o);
            end
            zeros = (bus.grant == '0) ? zeros + 1 : 0;
            prev = bus.grant;
        end
        bus.req = '0;
        n_tests++;
        if (order.size() !== 5) begin
            n_fail++;
            $display("FAIL rr_budget got=%0d grants want=5", order.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_tests++;
                if (order[k] !== want_order[k]) begin n_fail++; $display("FAIL rr_order idx=%0d got=%0d want=%0d", k, order[k], want_order[k]); end
            end
            foreach (gaps[k]) begin
                n_tests++;
                if (gaps[k] !== 3) begin n_fail++; $display("FAIL rr_gap idx=%0d got=%0d want=3", k, gaps[k]); end
            end
        end
        repeat (6) step();
    endtask

    task automatic test_dwell_zero();
        int show_cnt, last_show, done_at;
        for (int dv = 0; dv < 2; dv++) begin
            apply_reset();
            bus.pattern = 32'h0000_005A;
            bus.dwell   = DWELL_W'(dv);
            bus.req     = 4'b0001;
            show_cnt = 0; last_show = -1; done_at = -1;
            for (int i = 0; i < 6; i++) begin
                step();
                if (i == 0) bus.req = '0;  // drop on the completing cycle
                n_tests++;
                if ({bus.grant, bus.done, bus.led, bus.busy} !== {exp_grant, exp_done, exp_led, exp_busy}) begin
                    n_fail++;
                    $display("FAIL dwell%0d t=%0d got g=%b d=%b led=%h b=%b want g=%b d=%b led=%h b=%b",
                             dv, t, bus.grant, bus.done, bus.led, bus.busy, exp_grant, exp_done, exp_led, exp_busy);
                end
                if (bus.led == 8'h5A) begin show_cnt++; last_show = t; end
                if (bus.done[0] && done_at < 0) done_at = t;
            end
            n_tests++;
            if (show_cnt !== 1 || done_at !== last_show + 1) begin
                n_fail++;
                $display("FAIL dwell%0d_len got len=%0d done_at=%0d want len=1 done_at=%0d", dv, show_cnt, done_at, last_show + 1);
            end
        end
    endtask

    task automatic test_abort();
        int next_owner, saw_done;
        apply_reset();
        bus.pattern = 32'h0000_3311;
        bus.dwell   = 24'd5;
        bus.req     = 4'b0011;
        step();
        step();
        bus.req = 4'b0010;  // owner 0 drops on show cycle 2
        step();
        n_tests++;
        if (bus.led !== 8'h00 || bus.grant !== '0 || bus.done !== '0) begin
            n_fail++;
            $display("FAIL abort_blank got led=%h g=%b d=%b want led=00 g=0000 d=0000", bus.led, bus.grant, bus.done);
        end
        bus.req = 4'b0011;
        next_owner = -1; saw_done = 0;
        for (int i = 0; i < 20 && next_owner < 0; i++) begin
            step();
            n_tests++;
            if ({bus.grant, bus.done, bus.led, bus.busy} !== {exp_grant, exp_done, exp_led, exp_busy}) begin
                n_fail++;
                $display("FAIL abort t=%0d got g=%b d=%b led=%h b=%b want g=%b d=%b led=%h b=%b",
                         t, bus.grant, bus.done, bus.led, bus.busy, exp_grant, exp_done, exp_led, exp_busy);
            end
            if (bus.done != '0) saw_done = 1;
            for (int k = 0; k < int'(NREQ); k++) if (bus.grant[k]) next_owner = k;
        end
        bus.req = '0;
        n_tests++;
        if (next_owner !== 1 || saw_done !== 0) begin
            n_fail++;
            $display("FAIL abort_next got owner=%0d done_seen=%0d want owner=1 done_seen=0", next_owner, saw_done);
        end
        repeat (10) step();
    endtask

    task automatic test_latch();
        int show_cnt, bad_led;
        apply_reset();
        bus.pattern = 32'h0000_00A5;
        bus.dwell   = 24'd4;
        bus.req     = 4'b0001;
        step();
        bus.pattern = 32'h0000_003C;
        bus.dwell   = 24'd9;
        show_cnt = 1; bad_led = 0;
        if (bus.led != 8'hA5) bad_led++;
        for (int i = 0; i < 6; i++) begin
            step();
            n_tests++;
            if ({bus.grant, bus.done, bus.led, bus.busy} !== {exp_grant, exp_done, exp_led, exp_busy}) begin
                n_fail++;
                $display("FAIL latch t=%0d got g=%b d=%b led=%h b=%b want g=%b d=%b led=%h b=%b",
                         t, bus.grant, bus.done, bus.led, bus.busy, exp_grant, exp_done, exp_led, exp_busy);
            end
            if (bus.grant != '0) begin
                show_cnt++;
                if (bus.led != 8'hA5) bad_led++;
            end
        end
        bus.req = '0;
        n_tests++;
        if (show_cnt !== 4 || bad_led !== 0) begin
            n_fail++;
            $display("FAIL latch_hold got len=%0d bad_led=%0d want len=4 bad_led=0", show_cnt, bad_led);
        end
        repeat (4) step();
    endtask

    task automatic test_reset_mid_show();
        apply_reset();
        bus.pattern = 32'h0077_0066;
        bus.dwell   = 24'd6;
        bus.req     = 4'b0101;
        step();
        step();
        #2;
        nreset = 1'b0;
        #1;
        n_tests++;
        if ({bus.grant, bus.done, bus.led, bus.busy} !== '0) begin
            n_fail++;
            $display("FAIL midreset got g=%b d=%b led=%h b=%b want all zero", bus.grant, bus.done, bus.led, bus.busy);
        end
        model_reset();
        bus.req = 4'b1010;
        @(negedge clk);
        nreset = 1'b1;
        step();
        n_tests++;
        if (bus.grant !== 4'b0010 || bus.led !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_first got g=%b led=%h want g=0010 led=00", bus.grant, bus.led);
        end
        n_tests++;
        if ({bus.grant, bus.done, bus.led, bus.busy} !== {exp_grant, exp_done, exp_led, exp_busy}) begin
            n_fail++;
            $display("FAIL midreset_model t=%0d got g=%b d=%b led=%h b=%b want g=%b d=%b led=%h b=%b",
                     t, bus.grant, bus.done, bus.led, bus.busy, exp_grant, exp_done, exp_led, exp_busy);
        end
        bus.req = '0;
        repeat (12) step();
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3, 0) == 0) bus.req = NREQ'($urandom);
            if ($urandom_range(4, 0) == 0) bus.pattern = $urandom;
            if ($urandom_range(4, 0) == 0) bus.dwell = DWELL_W'($urandom_range(5, 0));
            step();
            n_tests++;
            if ({bus.grant, bus.done, bus.led, bus.busy} !== {exp_grant, exp_done, exp_led, exp_busy}) begin
                n_fail++;
                $display("FAIL random t=%0d got g=%b d=%b led=%h b=%b want g=%b d=%b led=%h b=%b",
                         t, bus.grant, bus.done, bus.led, bus.busy, exp_grant, exp_done, exp_led, exp_busy);
            end
        end
        bus.req = '0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        t       = 0;
        nreset  = 1'b0;
        bus.req     = '0;
        bus.pattern = '0;
        bus.dwell   = '0;
        model_reset();
        repeat (2) @(negedge clk);
        nreset = 1'b1;

        test_reset();
        test_single();
        test_round_robin();
        test_dwell_zero();
        test_abort();
        test_latch();
        test_reset_mid_show();
        test_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
